dmem_arbiter: RTL

//  Shares the single-port synchronous data RAM between three requesters: the CPU

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr_pick3.sv | 26 ++
 rtl/dmem_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: requester indices and
// round-robin pointer helpers.
package dmem_arbiter_pkg;

  localparam int NREQ    = 3;
  localparam int REQ_CPU = 0;
  localparam int REQ_VID = 1;
  localparam int REQ_KEY = 2;
  localparam int RR_W    = 2;

  typedef logic [NREQ-1:0] req_vec_t;
  typedef logic [RR_W-1:0] rr_ptr_t;

  // Pointer moves to the requester just after the one granted.
  function automatic rr_ptr_t next_ptr(input req_vec_t onehot);
    rr_ptr_t p;
    p = 2'd0;
    if (onehot[REQ_CPU]) p = 2'd1;
    if (onehot[REQ_VID]) p = 2'd2;
    if (onehot[REQ_KEY]) p = 2'd0;
    return p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches eligible requesters
// starting at ptr and returns a one-hot winner (zero if none eligible).
module rr_pick3
  import dmem_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_eligible,
  input  logic [RR_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_winner
);

  always_comb begin
    int  idx;
    logic found;
    o_winner = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(i_ptr) + k) % NREQ;
      if (!found && i_eligible[idx]) begin
        o_winner[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU, the display scanner
// (read-only) and the keypad/cell writer; one RAM cycle per grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int CPU_PRIORITY = 1
)
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata2,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rvalid;
  logic [RR_W-1:0] r_rr_ptr;

  logic [NREQ-1:0] w_eligible;
  logic [NREQ-1:0] w_rr_win;
  logic [NREQ-1:0] w_win;
  logic [NREQ-1:0] w_we_eff;
  logic            w_cpu_win;

  // The display scanner can never write.
  assign w_we_eff   = we & ~(NREQ'(1) << REQ_VID);
  assign w_eligible = req & ~r_gnt;
  assign w_cpu_win  = (CPU_PRIORITY != 0) && w_eligible[REQ_CPU];
  assign w_win      = w_cpu_win ? NREQ'(1) : w_rr_win;

  rr_pick3 u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr_ptr),
    .o_winner   (w_rr_win)
  );

  // Priority grants to the CPU leave the pointer alone, so requesters 1 and 2
  // alternate in the CPU's masked cycles instead of one of them starving.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_gnt    <= w_win;
      r_rvalid <= r_gnt & ~w_we_eff;
      if (!w_cpu_win && (|w_rr_win))
        r_rr_ptr <= next_ptr(w_rr_win);
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_gnt[REQ_CPU]) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (r_gnt[REQ_VID]) begin
      mem_addr  = addr1;
    end else if (r_gnt[REQ_KEY]) begin
      mem_addr  = addr2;
      mem_wdata = wdata2;
    end
  end

  assign mem_we    = |(r_gnt & w_we_eff);
  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = mem_rdata;
  assign cpu_stall = req[REQ_CPU] & ~r_gnt[REQ_CPU];

endmodule
